// File: rtl/e1b_code_loader_pkg.sv
// Shared constants, state encoding and helpers for the E1B code loader.
// Parameter defaults live here so the loader itself carries no private copies.
package e1b_code_loader_pkg;

  localparam int DEF_E1B_CODELEN  = 4092;
  localparam int DEF_E1B_CODEBITS = 12;
  localparam int DEF_V_GPS_CHANS  = 12;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_CLEAR,
    ST_LOAD,
    ST_DONE
  } state_e;

  // Lanes at or above chans are not wired to a channel and always write 0.
  function automatic logic [11:0] lane_mask(input int chans);
    return 12'((13'd1 << chans) - 13'd1);
  endfunction

  function automatic logic [15:0] csum_next(input logic [15:0] c, input logic [11:0] w);
    return {c[14:0], c[15]} ^ {4'b0000, w};
  endfunction

endpackage

// File: rtl/e1b_code_loader.sv
// Streams host E1B code words into the code memory: clear pulse, gated writes,
// word counter, rotate-XOR checksum and sticky status flags.
module e1b_code_loader
  import e1b_code_loader_pkg::*;
#(
  parameter int E1B_CODELEN  = DEF_E1B_CODELEN,
  parameter int E1B_CODEBITS = DEF_E1B_CODEBITS,
  parameter int V_GPS_CHANS  = DEF_V_GPS_CHANS
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic                    abort,
  input  logic                    din_valid,
  input  logic [11:0]             din,
  output logic                    din_ready,
  output logic                    mem_rst,
  output logic                    wr,
  output logic [11:0]             tos,
  output logic [E1B_CODEBITS-1:0] word_cnt,
  output logic [15:0]             csum,
  output logic                    done,
  output logic                    err_overflow,
  output logic                    err_short
);

  localparam logic [11:0]             LANE_MASK = lane_mask(V_GPS_CHANS);
  localparam logic [E1B_CODEBITS-1:0] LAST_IDX  = E1B_CODEBITS'(E1B_CODELEN - 1);

  state_e                  state_q, state_d;
  logic                    wr_q, wr_d;
  logic [11:0]             tos_q, tos_d;
  logic [E1B_CODEBITS-1:0] word_cnt_q, word_cnt_d;
  logic [15:0]             csum_q, csum_d;
  logic                    done_q, done_d;
  logic                    err_overflow_q, err_overflow_d;
  logic                    err_short_q, err_short_d;
  logic                    accept;
  logic                    final_accept;

  // NOTE: every signal written here gets a default first, so no path through the
  // case statement can leave one unassigned and infer a latch.
  always_comb begin
    state_d        = state_q;
    wr_d           = 1'b0;
    tos_d          = tos_q;
    word_cnt_d     = word_cnt_q;
    csum_d         = csum_q;
    done_d         = done_q;
    err_overflow_d = err_overflow_q;
    err_short_d    = err_short_q;

    // A start or reset cycle never accepts, so an old word cannot leak into a new load.
    din_ready    = (state_q == ST_LOAD) && !start && !rst;
    mem_rst      = (state_q == ST_CLEAR) && !rst;
    accept       = din_valid && din_ready;
    final_accept = accept && (word_cnt_q == LAST_IDX);

    if (accept) begin
      wr_d  = 1'b1;
      tos_d = din & LANE_MASK;
    end

    if (start) begin
      state_d        = ST_CLEAR;
      word_cnt_d     = '0;
      csum_d         = '0;
      done_d         = 1'b0;
      err_overflow_d = 1'b0;
      err_short_d    = 1'b0;
    end else begin
      case (state_q)
        ST_CLEAR: state_d = ST_LOAD;
        ST_LOAD: begin
          if (accept) begin
            word_cnt_d = word_cnt_q + E1B_CODEBITS'(1);
            csum_d     = csum_next(csum_q, din & LANE_MASK);
          end
          // The final word outranks abort: the load is complete, not short.
          if (final_accept) begin
            state_d = ST_DONE;
            done_d  = 1'b1;
          end else if (abort) begin
            state_d     = ST_IDLE;
            err_short_d = 1'b1;
          end
        end
        ST_IDLE, ST_DONE: begin
          if (din_valid) err_overflow_d = 1'b1;
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge value of every other flop, independent of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= ST_IDLE;
      wr_q           <= 1'b0;
      tos_q          <= '0;
      word_cnt_q     <= '0;
      csum_q         <= '0;
      done_q         <= 1'b0;
      err_overflow_q <= 1'b0;
      err_short_q    <= 1'b0;
    end else begin
      state_q        <= state_d;
      wr_q           <= wr_d;
      tos_q          <= tos_d;
      word_cnt_q     <= word_cnt_d;
      csum_q         <= csum_d;
      done_q         <= done_d;
      err_overflow_q <= err_overflow_d;
      err_short_q    <= err_short_d;
    end
  end

  assign wr           = wr_q;
  assign tos          = tos_q;
  assign word_cnt     = word_cnt_q;
  assign csum         = csum_q;
  assign done         = done_q;
  assign err_overflow = err_overflow_q;
  assign err_short    = err_short_q;

endmodule

// File: doc/e1b_code_loader.md
E1B_CODE_LOADER -- requirements
Module: e1b_code_loader

Interface
REQ-001 Parameter E1B_CODELEN, default 4092: number of 12-bit code words per complete load.
REQ-002 Parameter E1B_CODEBITS, default 12: width of the word counter.
REQ-003 Parameter V_GPS_CHANS, default 12: number of live code lanes per word (1..12).
REQ-004 clk  in  1  sole clock; all logic on posedge clk.
REQ-005 rst  in  1  reset, synchronous, active-high.
REQ-006 start  in  1  single-cycle pulse; begins a new load.
REQ-007 abort  in  1  single-cycle pulse; terminates a load in progress.
REQ-008 din_valid  in  1  host word valid.
REQ-009 din  in  12  host code word; bit n is the code chip for lane n.
REQ-010 din_ready  out  1  loader accepts din this cycle.
REQ-011 mem_rst  out  1  one-cycle pulse that restarts the code memory write pointer.
REQ-012 wr  out  1  code memory write strobe.
REQ-013 tos  out  12  code memory write data.
REQ-014 word_cnt  out  E1B_CODEBITS  words accepted in the current load.
REQ-015 csum  out  16  running checksum of accepted words.
REQ-016 done  out  1  sticky; full load completed.
REQ-017 err_overflow  out  1  sticky; word offered while not loading.
REQ-018 err_short  out  1  sticky; load aborted before E1B_CODELEN words.

Function
REQ-019 FSM states: IDLE, CLEAR, LOAD, DONE.
REQ-020 start in any state SHALL move the FSM to CLEAR on the next cycle; it clears word_cnt, csum, done, err_overflow and err_short.
REQ-021 CLEAR SHALL last exactly one cycle with mem_rst=1 and din_ready=0, then move to LOAD.
REQ-022 din_ready SHALL be 1 only in LOAD; accept = din_valid & din_ready.
REQ-023 On accept, wr=1 and tos={din[11:V_GPS_CHANS] forced 0, din[V_GPS_CHANS-1:0]} SHALL appear the following cycle (latency 1); otherwise wr=0 and tos holds its value.
REQ-024 On accept, word_cnt increments by 1, and csum <= {csum[14:0], csum[15]} XOR {4'b0, masked din}.
REQ-025 The accept that makes word_cnt equal E1B_CODELEN SHALL move the FSM to DONE and set done the same edge; din_ready drops the next cycle.
REQ-026 word_cnt SHALL never exceed E1B_CODELEN; there is no wrap-around.
REQ-027 din_valid=1 in IDLE or DONE SHALL set err_overflow; the word is dropped and no wr is issued.
REQ-028 din_valid=1 in CLEAR is neither accepted nor an error.
REQ-029 abort in LOAD SHALL move the FSM to IDLE and set err_short; abort in other states is ignored.
REQ-030 If start and abort occur in the same cycle, start wins.
REQ-031 If abort coincides with the final accept, the word is written and the FSM goes to DONE; err_short stays 0.
REQ-032 start in LOAD SHALL restart cleanly; any wr already in flight from the previous cycle still issues.
REQ-033 The mem_rst pulse SHALL precede the first wr of a load by at least one cycle.

Reset
REQ-034 rst SHALL force: FSM=IDLE, din_ready=0, mem_rst=0, wr=0, tos=0, word_cnt=0, csum=0, done=0, err_overflow=0, err_short=0.
REQ-035 rst overrides start and abort.
REQ-036 rst mid-load SHALL discard the load without setting err_short, and no wr is issued on the cycle after rst.

Structure
REQ-037 E1B_CODELEN, E1B_CODEBITS and V_GPS_CHANS SHALL come from the shared generated include (kiwi.gen.vh); the module defines no local copies.
REQ-038 Single flat module; FSM, counter and checksum inline; no sub-module.

Verification
REQ-039 Bench SHALL cover the scenarios below, with E1B_CODELEN=8 and V_GPS_CHANS=12 unless noted.
- Full load: start, then 8 back-to-back words 0x001..0x008 -> mem_rst one cycle after start; 8 wr pulses each 1 cycle after accept; word_cnt=8; done=1; csum matches the reference rotate-XOR model.
- Gapped valid: same 8 words with random 0-3 idle cycles between them -> identical wr/tos sequence and csum; done=1.
- Overflow: after done, din_valid=1 with 0xFFF -> err_overflow=1, no wr, word_cnt stays 8.
- Abort: start, 3 words, abort -> FSM IDLE, err_short=1, word_cnt=3, done=0; abort coinciding with the 8th accept -> done=1, err_short=0.
- Lane mask with V_GPS_CHANS=8: din=0xFAB -> tos=0x0AB.
- Restart: start mid-load after 5 words -> counters and flags cleared, new mem_rst pulse; rst during LOAD -> all outputs 0 next cycle.
